// File: rtl/like_alu_pkg.sv
// Shared constants for the like_alu slice: default width and the 2-bit opcode map.
package like_alu_pkg;

  localparam int WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  // ADD and SUB both go through the adder; they are the only carry producers.
  function automatic logic op_uses_adder(input logic [1:0] sel);
    return (sel == OP_ADD) || (sel == OP_SUB);
  endfunction

endpackage

// File: rtl/like_alu_adder.sv
// WIDTH-bit ripple-carry adder with carry-in and carry-out; shared by ADD and SUB.
module like_alu_adder #(
  parameter int WIDTH = like_alu_pkg::WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  logic c;

  // Carry walks from bit 0 upward, one full-adder cell per bit.
  always_comb begin
    s = '0;
    c = ci;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/like_alu.sv
// Registered 4-op ALU (ADD/SUB/AND/OR), one-cycle latency.
// Define LIKE_ALU_FLAGS_EN to add registered carry/no-borrow and zero flag ports.
module like_alu
  import like_alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inp_A,
  input  logic [WIDTH-1:0] inp_B,
  input  logic [1:0]       select,
`ifdef LIKE_ALU_FLAGS_EN
  output logic             carry,
  output logic             zero,
`endif
  output logic [WIDTH-1:0] out
);

  logic             is_sub;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_s;
  logic             add_co;
  logic [WIDTH-1:0] res;

  // SUB is A + ~B + 1, so the adder's carry-out reads as "no borrow".
  assign is_sub = (select == OP_SUB);
  assign add_b  = is_sub ? ~inp_B : inp_B;

  like_alu_adder #(.WIDTH(WIDTH)) u_adder (
    .a  (inp_A),
    .b  (add_b),
    .ci (is_sub),
    .s  (add_s),
    .co (add_co)
  );

  always_comb begin
    res = '0;
    unique case (select)
      OP_ADD,
      OP_SUB: res = add_s;
      OP_AND: res = inp_A & inp_B;
      OP_OR:  res = inp_A | inp_B;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= '0;
    else        out <= res;
  end

`ifdef LIKE_ALU_FLAGS_EN
  logic carry_nxt;
  logic zero_nxt;

  assign carry_nxt = op_uses_adder(select) & add_co;
  assign zero_nxt  = ~|res;

  // Flags clear on reset even though out is then zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b0;
      zero  <= 1'b0;
    end else begin
      carry <= carry_nxt;
      zero  <= zero_nxt;
    end
  end
`else
  logic unused_co;
  assign unused_co = add_co;
`endif

endmodule

// File: tb/tb_like_alu.sv
// Directed self-checking bench for like_alu (WIDTH=5); flag checks only when LIKE_ALU_FLAGS_EN is defined.
module tb_like_alu;

  localparam int W = 5;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] inp_A;
  logic [W-1:0] inp_B;
  logic [1:0]   select;
  logic [W-1:0] out;
`ifdef LIKE_ALU_FLAGS_EN
  logic         carry;
  logic         zero;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  like_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .inp_A  (inp_A),
    .inp_B  (inp_B),
    .select (select),
`ifdef LIKE_ALU_FLAGS_EN
    .carry  (carry),
    .zero   (zero),
`endif
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic chk_res(input string tag, input logic [W-1:0] eo, input logic ec, input logic ez);
    chk({tag, ".out"}, 32'(out), 32'(eo));
`ifdef LIKE_ALU_FLAGS_EN
    chk({tag, ".carry"}, 32'(carry), 32'(ec));
    chk({tag, ".zero"},  32'(zero),  32'(ez));
`else
    if (ec === 1'bz && ez === 1'bz) $display("note: %s flags not built", tag);
`endif
  endtask

  typedef struct {
    string        tag;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   sel;
    logic [W-1:0] eo;
    logic         ec;
    logic         ez;
  } vec_t;

  vec_t vecs[$];

  // Inputs change on the falling edge, are captured on the rising edge, checked on the next falling edge.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] sel);
    inp_A  = a;
    inp_B  = b;
    select = sel;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs.push_back('{"a21b31_add", 5'b10101, 5'b11111, 2'b00, 5'b10100, 1'b1, 1'b0});
    vecs.push_back('{"a21b31_sub", 5'b10101, 5'b11111, 2'b01, 5'b10110, 1'b0, 1'b0});
    vecs.push_back('{"a21b31_and", 5'b10101, 5'b11111, 2'b10, 5'b10101, 1'b0, 1'b0});
    vecs.push_back('{"a21b31_or",  5'b10101, 5'b11111, 2'b11, 5'b11111, 1'b0, 1'b0});
    vecs.push_back('{"a31b31_add", 5'b11111, 5'b11111, 2'b00, 5'b11110, 1'b1, 1'b0});
    vecs.push_back('{"a31b31_sub", 5'b11111, 5'b11111, 2'b01, 5'b00000, 1'b1, 1'b1});
    vecs.push_back('{"a31b31_and", 5'b11111, 5'b11111, 2'b10, 5'b11111, 1'b0, 1'b0});
    vecs.push_back('{"a31b31_or",  5'b11111, 5'b11111, 2'b11, 5'b11111, 1'b0, 1'b0});
    vecs.push_back('{"zero_add",   5'b00000, 5'b00000, 2'b00, 5'b00000, 1'b0, 1'b1});
    vecs.push_back('{"a3b5_sub",   5'b00011, 5'b00101, 2'b01, 5'b11110, 1'b0, 1'b0});
    vecs.push_back('{"a9b9_sub",   5'b01001, 5'b01001, 2'b01, 5'b00000, 1'b1, 1'b1});
    vecs.push_back('{"disj_and",   5'b10101, 5'b01010, 2'b10, 5'b00000, 1'b0, 1'b1});
    vecs.push_back('{"disj_or",    5'b10101, 5'b01010, 2'b11, 5'b11111, 1'b0, 1'b0});
    vecs.push_back('{"a16b16_add", 5'b10000, 5'b10000, 2'b00, 5'b00000, 1'b1, 1'b1});
    vecs.push_back('{"a7b1_add",   5'b00111, 5'b00001, 2'b00, 5'b01000, 1'b0, 1'b0});

    rst_n  = 1'b0;
    inp_A  = 5'b10101;
    inp_B  = 5'b11111;
    select = 2'b00;
    #1;
    chk_res("reset_t0", 5'b00000, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk_res("reset_held", 5'b00000, 1'b0, 1'b0);

    // First edge after release loads the inputs present at that edge.
    rst_n = 1'b1;
    step(5'b00110, 5'b00011, 2'b01);
    chk_res("post_reset_sub", 5'b00011, 1'b1, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].b, vecs[i].sel);
      chk_res(vecs[i].tag, vecs[i].eo, vecs[i].ec, vecs[i].ez);
    end

    // Latency: out holds between edges regardless of input changes.
    step(5'b00001, 5'b00010, 2'b00);
    chk_res("lat_base", 5'b00011, 1'b0, 1'b0);
    inp_A = 5'b11111; inp_B = 5'b11111; select = 2'b11;
    #2;
    chk("lat_hold1.out", 32'(out), 32'(5'b00011));
    inp_A = 5'b00000; select = 2'b10;
    #1;
    chk("lat_hold2.out", 32'(out), 32'(5'b00011));
    @(posedge clk); #1;
    chk_res("lat_update", 5'b00000, 1'b0, 1'b1);
    @(negedge clk);

    // Mid-cycle async reset with out nonzero, pending result discarded.
    step(5'b11000, 5'b00101, 2'b11);
    chk_res("pre_rst", 5'b11101, 1'b0, 1'b0);
    inp_A = 5'b01111; inp_B = 5'b00001; select = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    chk_res("async_rst", 5'b00000, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_res("rst_over_edge", 5'b00000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(5'b01111, 5'b00001, 2'b00);
    chk_res("rst_release_add", 5'b10000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/like_alu.md
LIKE_ALU -- requirements
Module: like_alu

Interface
REQ-001 Parameter WIDTH, default 5, sets the operand and result bit width; all values below assume WIDTH=5.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 out  output  WIDTH  registered result.
REQ-005 inp_A  input  WIDTH  operand A, unsigned.
REQ-006 inp_B  input  WIDTH  operand B, unsigned.
REQ-007 select  input  2  operation code.
REQ-008 carry  output  1  registered carry/no-borrow flag; present only with LIKE_ALU_FLAGS_EN.
REQ-009 zero  output  1  registered zero flag; present only with LIKE_ALU_FLAGS_EN.

Function
REQ-010 The block SHALL decode select as: 00 ADD (A+B), 01 SUB (A-B), 10 AND (A&B), 11 OR (A|B).
REQ-011 ADD SHALL produce the result modulo 2^WIDTH; carry = bit WIDTH of the full sum.
REQ-012 SUB SHALL be computed as A + ~B + 1, result modulo 2^WIDTH; carry = adder carry-out (1 = no borrow, i.e. A>=B; 0 = borrow).
REQ-013 AND and OR SHALL be bitwise; carry = 0 for both.
REQ-014 zero SHALL be 1 exactly when the WIDTH-bit result is all zeros, for every operation.
REQ-015 Result and flags SHALL be computed combinationally from the current inputs and registered on each rising clk edge; latency is exactly one cycle, no enable, no handshake.
REQ-016 A new operation SHALL be accepted every cycle; input changes between edges SHALL NOT affect out until the next edge.
REQ-017 Operands SHALL be treated as unsigned; no overflow flag.

Reset
REQ-018 While rst_n=0, out, carry and zero SHALL be forced to 0 immediately, independent of clk.
REQ-019 After rst_n deasserts, the first rising edge SHALL load the result of the inputs present at that edge.
REQ-020 Reset asserted mid-operation SHALL discard the pending result; no state other than the output registers exists.

Configuration
REQ-021 Macro LIKE_ALU_FLAGS_EN: when defined, the carry and zero ports and their registers SHALL exist per REQ-011..REQ-014.
REQ-022 When LIKE_ALU_FLAGS_EN is undefined, carry and zero ports and logic SHALL be absent; out behaviour SHALL be identical.

Structure
REQ-023 Shared package like_alu_pkg SHALL hold the WIDTH default and the 2-bit opcode constants OP_ADD=00, OP_SUB=01, OP_AND=10, OP_OR=11.
REQ-024 ADD and SUB SHALL share one sub-module, like_alu_adder: a WIDTH-bit ripple-carry adder with carry-in and carry-out, with B inverted and carry-in=1 for SUB.
REQ-025 Operation select SHALL be a 4-way mux feeding the output registers.

Verification
REQ-026 Reset: rst_n=0 with out previously nonzero -> out=00000, carry=0, zero=0 before the next clk edge.
REQ-027 A=10101, B=11111, select=00/01/10/11 in consecutive cycles -> one cycle later, in sequence: out=10100 carry=1; out=10110 carry=0; out=10101; out=11111; zero=0 throughout.
REQ-028 A=11111, B=11111, select=00/01/10/11 in consecutive cycles -> out=11110 carry=1; out=00000 carry=1 zero=1; out=11111; out=11111.
REQ-029 Latency: change the inputs between clock edges -> out holds its previous value until the next rising edge.
REQ-030 Build without LIKE_ALU_FLAGS_EN and rerun REQ-027 -> identical out sequence, no carry or zero ports.
